apb_requester: RTL and testbench
================================

APB_REQUESTER -- requirements
Module: apb_requester

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, PADDR/cmd_addr width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; legal values are 8, 16 and 32.
REQ-003 SHALL have parameter TIMEOUT, default 16, maximum ACCESS-phase cycles without PREADY; a value of 0 disables the timeout.
REQ-004 SHALL have the following ports: PCLK  in  1  sole clock, rising edge.
REQ-005 PRESETn  in  1  asynchronous, active-low reset.
REQ-006 cmd_valid  in  1  command offered; cmd_ready  out  1  command accepted when both are high at a PCLK edge.
REQ-007 cmd_write  in  1  1 = write, 0 = read; cmd_addr  in  ADDR_WIDTH; cmd_wdata  in  DATA_WIDTH; cmd_strb  in  DATA_WIDTH/8.
REQ-008 rsp_valid  out  1; rsp_ready  in  1; rsp_rdata  out  DATA_WIDTH; rsp_error  out  1; rsp_timeout  out  1.
REQ-009 PSEL, PENABLE, PWRITE  out  1 each; PADDR  out  ADDR_WIDTH; PWDATA  out  DATA_WIDTH; PSTRB  out  DATA_WIDTH/8.
REQ-010 PREADY  in  1; PRDATA  in  DATA_WIDTH; PSLVERR  in  1.

Function
REQ-011 SHALL implement an FSM with states IDLE, SETUP, ACCESS and RESP; all outputs SHALL be registered.
REQ-012 cmd_ready SHALL be 1 only in IDLE.
REQ-013 A command accepted in IDLE at edge k SHALL put the FSM in SETUP for cycle k+1 (PSEL=1, PENABLE=0) and in ACCESS from cycle k+2 (PSEL=1, PENABLE=1).
REQ-014 PADDR, PWRITE, PWDATA and PSTRB SHALL be captured at acceptance and held stable from SETUP until the transfer ends.
REQ-015 On a read, PSTRB SHALL be all-zero and PWDATA SHALL be 0.
REQ-016 ACCESS SHALL persist while PREADY=0; the first ACCESS cycle with PREADY=1 ends the transfer.
REQ-017 At transfer end: PSEL=0 and PENABLE=0 on the next cycle; FSM enters RESP.
REQ-018 On the same transition, rsp_error<=PSLVERR and rsp_timeout<=0.
REQ-019 On the same transition, rsp_rdata<=PRDATA for a read and 0 for a write.
REQ-020 With PREADY=1 on the first ACCESS cycle, rsp_valid SHALL be 1 in cycle k+3.
REQ-021 The wait counter SHALL clear on SETUP entry and increment on each ACCESS cycle with PREADY=0; it SHALL saturate and never wrap.
REQ-022 If TIMEOUT>0 and the count reaches TIMEOUT, the transfer SHALL abort: PSEL=0, PENABLE=0 next cycle.
REQ-023 On timeout abort: rsp_error=1, rsp_timeout=1, rsp_rdata=0, then RESP.
REQ-024 PREADY=1 on the same cycle the count reaches TIMEOUT SHALL count as normal completion, not timeout.
REQ-025 In RESP, rsp_valid=1 and response fields SHALL be held until rsp_valid and rsp_ready are both high at an edge; the FSM then returns to IDLE with rsp_valid=0 on the next cycle.
REQ-026 PRDATA and PSLVERR SHALL be ignored outside the completing ACCESS cycle.
REQ-027 cmd_* inputs SHALL be ignored outside IDLE.
REQ-028 Minimum command-to-command spacing SHALL be 4 cycles (IDLE, SETUP, ACCESS, RESP).

Reset
REQ-029 PRESETn=0 SHALL, asynchronously, force the FSM to IDLE and all outputs to 0 except cmd_ready; the wait counter SHALL also clear.
REQ-030 cmd_ready SHALL be 0 while PRESETn=0 and 1 from the first edge after deassertion.
REQ-031 Reset during SETUP, ACCESS or RESP SHALL drop the in-flight transfer; no response SHALL be produced for it afterwards.

Verification
REQ-032 Write, zero wait: cmd addr=0x0010, wdata=0xDEADBEEF, strb=0xF; PREADY=1 -> SETUP then one ACCESS cycle; rsp_valid at k+3 with rsp_error=0 and rsp_rdata=0.
REQ-033 Read, 3 waits: PREADY low for 3 ACCESS cycles, PRDATA=0x12345678 -> PENABLE high for 4 cycles; rsp_rdata=0x12345678; PSTRB=0 throughout.
REQ-034 Slave error: PSLVERR=1 with PREADY=1 -> rsp_error=1, rsp_timeout=0.
REQ-035 Timeout: TIMEOUT=16, PREADY tied 0 -> abort after 16 ACCESS cycles, rsp_error=1, rsp_timeout=1; also PREADY=1 on cycle 16 -> normal completion.
REQ-036 Backpressure: rsp_ready=0 for 5 cycles -> rsp fields stable, cmd_ready=0, PSEL=0; with rsp_ready=1, back-to-back commands accepted every 4 cycles.
REQ-037 Reset mid-ACCESS: PRESETn low during ACCESS -> PSEL, PENABLE and rsp_valid 0 immediately; no response after release.

Source files
------------

// File: rtl/apb_requester.sv
// APB requester: turns a valid/ready command into one APB transfer and returns
// the completion (read data, slave error, timeout) on a valid/ready response port.
module apb_requester #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_error,
  output logic                    rsp_timeout,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  output logic [DATA_WIDTH/8-1:0] PSTRB,
  input  logic                    PREADY,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  input  logic                    PSLVERR
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int CNT_WIDTH  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int CNT_LAST   = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                state, state_nxt;
  logic [CNT_WIDTH-1:0]  wait_cnt, wait_cnt_nxt;
  logic                  cmd_ready_nxt, rsp_valid_nxt, rsp_error_nxt, rsp_timeout_nxt;
  logic [DATA_WIDTH-1:0] rsp_rdata_nxt, pwdata_nxt;
  logic                  psel_nxt, penable_nxt, pwrite_nxt;
  logic [ADDR_WIDTH-1:0] paddr_nxt;
  logic [STRB_WIDTH-1:0] pstrb_nxt;
  logic                  timeout_hit;

  // The wait cycle that would bring the count up to TIMEOUT is the last one allowed.
  assign timeout_hit = (TIMEOUT > 0) && (wait_cnt == CNT_WIDTH'(CNT_LAST));

  always_comb begin
    // NOTE: every signal gets a default first, so no path can leave one unassigned and infer a latch.
    state_nxt       = state;
    wait_cnt_nxt    = wait_cnt;
    cmd_ready_nxt   = cmd_ready;
    rsp_valid_nxt   = rsp_valid;
    rsp_rdata_nxt   = rsp_rdata;
    rsp_error_nxt   = rsp_error;
    rsp_timeout_nxt = rsp_timeout;
    psel_nxt        = PSEL;
    penable_nxt     = PENABLE;
    pwrite_nxt      = PWRITE;
    paddr_nxt       = PADDR;
    pwdata_nxt      = PWDATA;
    pstrb_nxt       = PSTRB;

    case (state)
      IDLE: begin
        cmd_ready_nxt = 1'b1;
        if (cmd_valid && cmd_ready) begin
          state_nxt     = SETUP;
          cmd_ready_nxt = 1'b0;
          wait_cnt_nxt  = '0;
          psel_nxt      = 1'b1;
          penable_nxt   = 1'b0;
          pwrite_nxt    = cmd_write;
          paddr_nxt     = cmd_addr;
          pwdata_nxt    = cmd_write ? cmd_wdata : '0;
          pstrb_nxt     = cmd_write ? cmd_strb  : '0;
        end
      end
      SETUP: begin
        state_nxt   = ACCESS;
        penable_nxt = 1'b1;
      end
      ACCESS: begin
        if (PREADY) begin
          state_nxt       = RESP;
          psel_nxt        = 1'b0;
          penable_nxt     = 1'b0;
          rsp_valid_nxt   = 1'b1;
          rsp_error_nxt   = PSLVERR;
          rsp_timeout_nxt = 1'b0;
          rsp_rdata_nxt   = PWRITE ? '0 : PRDATA;
        end else begin
          wait_cnt_nxt = (wait_cnt == '1) ? wait_cnt : wait_cnt + 1'b1;
          if (timeout_hit) begin
            state_nxt       = RESP;
            psel_nxt        = 1'b0;
            penable_nxt     = 1'b0;
            rsp_valid_nxt   = 1'b1;
            rsp_error_nxt   = 1'b1;
            rsp_timeout_nxt = 1'b1;
            rsp_rdata_nxt   = '0;
          end
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt     = IDLE;
          rsp_valid_nxt = 1'b0;
          cmd_ready_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_error   <= 1'b0;
      rsp_timeout <= 1'b0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      PSTRB       <= '0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_cnt_nxt;
      cmd_ready   <= cmd_ready_nxt;
      rsp_valid   <= rsp_valid_nxt;
      rsp_rdata   <= rsp_rdata_nxt;
      rsp_error   <= rsp_error_nxt;
      rsp_timeout <= rsp_timeout_nxt;
      PSEL        <= psel_nxt;
      PENABLE     <= penable_nxt;
      PWRITE      <= pwrite_nxt;
      PADDR       <= paddr_nxt;
      PWDATA      <= pwdata_nxt;
      PSTRB       <= pstrb_nxt;
    end
  end

endmodule

// File: tb/tb_apb_requester.sv
// Self-checking bench for apb_requester: a scripted APB slave drives each transfer,
// expected responses go through a scoreboard queue checked at the response handshake.
module tb_apb_requester;

  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic          PCLK, PRESETn;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [3:0]    cmd_strb;
  logic          rsp_valid, rsp_ready, rsp_error, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic          PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA, PRDATA;
  logic [3:0]    PSTRB;

  apb_requester #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          error;
    logic          timeout;
  } rsp_t;

  rsp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   acc_cyc;

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: pop and compare on every response handshake.
  always @(negedge PCLK) begin
    if (PRESETn && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", 1'b1, 1'b0);
      end else begin
        rsp_t e;
        e = sb.pop_front();
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_error", rsp_error, e.error);
        check("rsp_timeout", rsp_timeout, e.timeout);
      end
    end
  end

  // One full transfer. waits = ACCESS cycles with PREADY low before PREADY high;
  // waits >= TMO means PREADY never rises. stall = RESP cycles with rsp_ready low.
  task automatic run_xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input logic [3:0] strb, input int waits, input logic [DW-1:0] rdata,
                          input logic err, input int stall);
    logic          to;
    int            acc, n;
    rsp_t          e;
    logic [52:0]   exp_bus;
    to  = (waits >= TMO);
    acc = to ? TMO : waits + 1;
    exp_bus = {wr, (wr ? strb : 4'h0), addr, (wr ? wdata : 32'h0)};
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(posedge PCLK); #1; n++;
    end
    check("cmd_ready_wait", cmd_ready, 1'b1);
    e.rdata   = (wr || to) ? '0 : rdata;
    e.error   = to ? 1'b1 : err;
    e.timeout = to;
    sb.push_back(e);
    rsp_ready = (stall == 0);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_strb = strb;
    @(posedge PCLK); #1;
    acc_cyc = cyc;
    // SETUP: command inputs change and stay valid; all must be ignored.
    cmd_write = ~wr; cmd_addr = ~addr; cmd_wdata = ~wdata; cmd_strb = ~strb;
    check("setup_sel_en", {PSEL, PENABLE}, 2'b10);
    check("setup_bus", {PWRITE, PSTRB, PADDR, PWDATA}, exp_bus);
    check("setup_cmd_ready", cmd_ready, 1'b0);
    PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = $urandom;
    for (int i = 0; i < acc; i++) begin
      @(posedge PCLK); #1;
      check("access_sel_en", {PSEL, PENABLE}, 2'b11);
      check("access_bus", {PWRITE, PSTRB, PADDR, PWDATA}, exp_bus);
      if (i == waits) begin
        PREADY = 1'b1; PRDATA = rdata; PSLVERR = err;
      end else begin
        PREADY = 1'b0; PRDATA = $urandom; PSLVERR = ~err;
      end
    end
    @(posedge PCLK); #1;
    cmd_valid = 1'b0; PREADY = 1'b0;
    check("resp_sel_en", {PSEL, PENABLE}, 2'b00);
    check("resp_valid", rsp_valid, 1'b1);
    for (int i = 0; i < stall; i++) begin
      check("stall_fields", {rsp_valid, rsp_error, rsp_timeout, rsp_rdata},
            {1'b1, e.error, e.timeout, e.rdata});
      check("stall_idle", {cmd_ready, PSEL}, 2'b00);
      @(posedge PCLK); #1;
    end
    rsp_ready = 1'b1;
    check("resp_held", rsp_valid, 1'b1);
    @(posedge PCLK); #1;
    check("back_idle", {rsp_valid, cmd_ready}, 2'b01);
  endtask

  initial begin
    int a0;
    logic seen;
    PRESETn = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0;
    rsp_ready = 1'b0; PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
    #1;
    check("reset_cmd_ready", cmd_ready, 1'b0);
    check("reset_outputs", {PSEL, PENABLE, rsp_valid, rsp_error, rsp_timeout}, 5'b0);
    #22 PRESETn = 1'b1;
    @(posedge PCLK); #1;
    check("cmd_ready_after_reset", cmd_ready, 1'b1);

    run_xfer(1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 0, 32'h0, 1'b0, 0);   // write, zero wait
    run_xfer(1'b0, 16'h0020, 32'hFFFFFFFF, 4'hF, 3, 32'h12345678, 1'b0, 0); // read, 3 waits
    run_xfer(1'b0, 16'h0030, 32'h0, 4'h0, 0, 32'hCAFEF00D, 1'b1, 0);    // slave error
    run_xfer(1'b1, 16'h0040, 32'h11112222, 4'h3, 1, 32'h0, 1'b1, 0);    // write error
    run_xfer(1'b0, 16'h0050, 32'h0, 4'h0, 100, 32'h0, 1'b0, 0);         // timeout
    run_xfer(1'b0, 16'h0060, 32'h0, 4'h0, TMO - 1, 32'hA5A55A5A, 1'b0, 0); // ready on last cycle
    run_xfer(1'b1, 16'h0070, 32'h01020304, 4'h5, 2, 32'h0, 1'b0, 5);    // backpressure

    run_xfer(1'b1, 16'h0100, 32'h00000001, 4'h1, 0, 32'h0, 1'b0, 0);
    a0 = acc_cyc;
    run_xfer(1'b0, 16'h0104, 32'h0, 4'h0, 0, 32'h0BADC0DE, 1'b0, 0);
    check("b2b_spacing_1", 64'(acc_cyc - a0), 64'd4);
    a0 = acc_cyc;
    run_xfer(1'b1, 16'h0108, 32'h00000003, 4'h8, 0, 32'h0, 1'b0, 0);
    check("b2b_spacing_2", 64'(acc_cyc - a0), 64'd4);

    // Reset in the middle of ACCESS: the transfer vanishes without a response.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0200;
    @(posedge PCLK); #1;
    cmd_valid = 1'b0; PREADY = 1'b0;
    @(posedge PCLK); #1;
    @(posedge PCLK); #1;
    check("pre_reset_access", {PSEL, PENABLE}, 2'b11);
    #1 PRESETn = 1'b0;
    #1;
    check("mid_reset_outputs", {PSEL, PENABLE, rsp_valid, cmd_ready}, 4'b0);
    #2 PRESETn = 1'b1;
    rsp_ready = 1'b1; PREADY = 1'b1; PRDATA = 32'hFFFF0000;
    @(posedge PCLK); #1;
    check("cmd_ready_after_midreset", cmd_ready, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge PCLK); #1;
      seen = seen | rsp_valid | PSEL;
    end
    check("no_rsp_after_reset", seen, 1'b0);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
